demux32to2_stream: RTL and testbench
====================================

# demux32to2_stream

Buffered 1-to-2 demultiplexer for 32-bit words. It is the steering counterpart of the 2-to-1 word mux on the datapath. A single producer stream is routed by a per-word select bit to one of two consumer channels. Each channel has a 2-entry FIFO and a valid/ready handshake, so a stalled consumer never corrupts or drops words destined for the other channel. It sits between the datapath result bus and two downstream sinks, for example register-file writeback and a store/output port.

## Interface
Parameters:
- DEPTH, 2, entries per output FIFO; fixed at 2 for this revision.
- CNT_W, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  reset is synchronous and active-low.
- in_data  input  32  word to route.
- in_sel  input  1  destination: 0 routes to channel 0, 1 routes to channel 1.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block will accept the word this cycle.
- out0_data  output  32  head word of channel 0 FIFO.
- out0_valid  output  1  channel 0 FIFO non-empty.
- out0_ready  input  1  channel 0 consumer takes the head word.
- out1_data, out1_valid, out1_ready: identical behaviour to the channel 0 ports, for channel 1.
- cnt0  output  CNT_W  words accepted into channel 0, modulo 2^CNT_W.
- cnt1  output  CNT_W  words accepted into channel 1, modulo 2^CNT_W.

## Operation
- Push: when in_valid && in_ready at a rising edge, in_data is written to the tail of the FIFO selected by in_sel. The matching cntN increments by 1.
- in_ready = NOT full(FIFO selected by in_sel).
  - in_ready is combinational from in_sel and registered occupancy only.
  - There is no path from out0_ready/out1_ready to in_ready.
- Pop: when outN_valid && outN_ready at a rising edge, the head of FIFO N is removed. outN_data then presents the next entry, if any.
- Each FIFO has occupancy 0, 1 or 2:
  - empty (0): outN_valid = 0.
  - one (1): outN_valid = 1.
  - full (2): outN_valid = 1, and the push side blocks that channel.
- Occupancy transitions per channel:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged. This is legal at occupancy 1. At occupancy 0 it cannot occur because valid is low. At occupancy 2 it cannot occur because in_ready is low for that channel.
- Channels are independent. A full or stalled channel 0 does not block words with in_sel = 1, and the reverse holds.
- Order is preserved within a channel. No ordering is implied across channels.
- When outN_valid = 0, outN_data holds its last value. The bench must not check it.
- The counters wrap from 2^CNT_W − 1 to 0 with no saturation. They count pushes, not pops.
- A word with in_valid = 0 has no effect, whatever in_sel is.

## Timing
- Reset (reset_n = 0 at a rising edge) forces:
  - both FIFO occupancies and read/write pointers to 0;
  - out0_valid = out1_valid = 0;
  - out0_data = out1_data = 32'h0;
  - cnt0 = cnt1 = 0.
- in_ready reads 1 one cycle after reset is released.
- While reset_n = 0, in_ready is held 0.
- Reset asserted mid-transfer discards all buffered words. Handshakes in that cycle are ignored.
- Latency: a word pushed at edge k appears on outN_data/outN_valid after edge k. It can be popped at edge k+1 at the earliest.
- Throughput: 1 word/cycle per direction, sustained, while the consumer holds ready = 1. Occupancy sits at 1 in this case.
- Backpressure: with the consumer stalled, a channel absorbs exactly 2 words. in_ready then drops for that channel until one pop occurs. in_ready rises in the cycle after the popping edge.

## Test plan
- Reset: hold reset_n = 0 for 3 cycles with in_valid = 1 -> no pushes; out*_valid = 0, cnt* = 0, out*_data = 0; in_ready = 1 after release.
- Streaming: push 32'hA0000000..32'hA0000007 alternating in_sel 0/1 with both readies at 1 -> channel 0 outputs A0,A2,A4,A6 and channel 1 outputs A1,A3,A5,A7, each 1 cycle after push; cnt0 = cnt1 = 4.
- Backpressure: out0_ready = 0, push 3 words to channel 0 -> first 2 accepted, in_ready = 0 on the third. Meanwhile a channel 1 push is accepted. Raise out0_ready for 1 cycle -> the third word is accepted next cycle, and channel 0 pops in FIFO order.
- Simultaneous: channel 1 at occupancy 1, push and pop on the same edge -> occupancy stays 1 and out1_data updates to the new word.
- Counter wrap: 256 pushes to channel 0 -> cnt0 goes 255 -> 0, cnt1 unchanged.
- Mid-operation reset: both FIFOs full, assert reset_n = 0 for 1 cycle -> both valids 0 next cycle, counters 0, no stale word ever emitted.

Source files
------------

// File: rtl/demux32to2_stream.sv
// Buffered 1-to-2 word demux: in_sel steers each accepted word into one of two
// independent 2-entry FIFOs, each with its own valid/ready drain and push counter.

module demux32to2_stream_chan #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             ready,
    output logic [W-1:0]     data,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PTR_W-1:0]        wptr, rptr;
    logic [OCC_W-1:0]        occ;
    logic                    pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign valid = (occ != '0);
    assign full  = (occ == FULL);
    assign data  = mem[rptr];
    assign pop   = valid & ready;

    // Clearing the storage on reset is what makes outN_data read zero afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= nxt(wptr);
                cnt       <= cnt + 1'b1;
            end
            if (pop)
                rptr <= nxt(rptr);
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

module demux32to2_stream #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [31:0]      out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    localparam int NUM_LANES = 2;
    localparam int VEC_W     = 32;

    logic [NUM_LANES-1:0][VEC_W-1:0] ch_data;
    logic [NUM_LANES-1:0][CNT_W-1:0] ch_cnt;
    logic [NUM_LANES-1:0]            ch_valid, ch_full, ch_ready, ch_push;
    logic                            rdy_en;

    // rdy_en delays in_ready by one edge after reset release; no consumer ready feeds it.
    always_ff @(posedge clk) begin
        if (!reset_n) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    assign in_ready = reset_n & rdy_en & ~ch_full[in_sel];
    assign ch_ready = {out1_ready, out0_ready};

    always_comb begin
        ch_push         = '0;
        ch_push[in_sel] = in_valid & in_ready;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux32to2_stream_chan #(
            .DEPTH (DEPTH),
            .W     (VEC_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (ch_push[g]),
            .wdata   (in_data),
            .ready   (ch_ready[g]),
            .data    (ch_data[g]),
            .valid   (ch_valid[g]),
            .full    (ch_full[g]),
            .cnt     (ch_cnt[g])
        );
    end

    assign out0_data  = ch_data[0];
    assign out1_data  = ch_data[1];
    assign out0_valid = ch_valid[0];
    assign out1_valid = ch_valid[1];
    assign cnt0       = ch_cnt[0];
    assign cnt1       = ch_cnt[1];
endmodule

// File: tb/tb_demux32to2_stream.sv
// Scoreboard bench for demux32to2_stream: accepted words are queued per channel
// and compared in order as the DUT pops them.

module tb_demux32to2_stream;
    logic        clk, reset_n;
    logic [31:0] in_data;
    logic        in_sel, in_valid, in_ready;
    logic [31:0] out0_data, out1_data;
    logic        out0_valid, out1_valid, out0_ready, out1_ready;
    logic [7:0]  cnt0, cnt1;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [7:0]  exp_cnt0 = 8'd0;
    logic [7:0]  exp_cnt1 = 8'd0;
    bit          mon_en = 1'b0;

    demux32to2_stream #(.DEPTH(2), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop side of the scoreboard: every handshake must deliver the oldest queued word.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (out0_valid && out0_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL ch0_pop unexpected word got=%h exp=none", out0_data);
                end else begin
                    logic [31:0] e;
                    e = q0.pop_front();
                    if (out0_data !== e) begin
                        failures++;
                        $display("FAIL ch0_pop got=%h exp=%h", out0_data, e);
                    end
                end
            end
            if (out1_valid && out1_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL ch1_pop unexpected word got=%h exp=none", out1_data);
                end else begin
                    logic [31:0] e;
                    e = q1.pop_front();
                    if (out1_data !== e) begin
                        failures++;
                        $display("FAIL ch1_pop got=%h exp=%h", out1_data, e);
                    end
                end
            end
        end
    end

    // Drives one cycle of input; the model records the push when the bench expects acceptance.
    task automatic step(input logic v, input logic [31:0] d, input logic s,
                        input logic exp_rdy, output logic rdy);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        @(negedge clk);
        rdy = in_ready;
        if (v && exp_rdy) begin
            if (s) begin q1.push_back(d); exp_cnt1 = exp_cnt1 + 8'd1; end
            else   begin q0.push_back(d); exp_cnt0 = exp_cnt0 + 8'd1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_sel = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got rdy=%b v0=%b v1=%b exp 0 0 0",
                         i, in_ready, out0_valid, out1_valid);
            end
            in_sel = ~in_sel;
        end
        checks++;
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0 || out0_data !== 32'h0 || out1_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got cnt0=%0d cnt1=%0d d0=%h d1=%h exp all 0",
                     cnt0, cnt1, out0_data, out1_data);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; in_valid = 1'b0; in_sel = 1'b0;
        q0.delete(); q1.delete(); exp_cnt0 = 8'd0; exp_cnt1 = 8'd0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_streaming();
        logic rdy;
        logic [31:0] w;
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic s;
            s = i[0];
            w = 32'hA0000000 + 32'(i);
            step(1'b1, w, s, 1'b1, rdy);
            checks++;
            if (rdy !== 1'b1 || (s ? (out1_valid !== 1'b1 || out1_data !== w)
                                   : (out0_valid !== 1'b1 || out0_data !== w))) begin
                failures++;
                $display("FAIL stream_latency i=%0d got rdy=%b d0=%h v0=%b d1=%h v1=%b exp word %h on ch%0d",
                         i, rdy, out0_data, out0_valid, out1_data, out1_valid, w, s);
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        checks++;
        if (cnt0 !== 8'd4 || cnt1 !== 8'd4 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_counts got cnt0=%0d cnt1=%0d v0=%b v1=%b exp 4 4 0 0",
                     cnt0, cnt1, out0_valid, out1_valid);
        end
    endtask

    task automatic test_backpressure();
        logic rdy;
        out0_ready = 1'b0; out1_ready = 1'b1;
        step(1'b1, 32'hB0000000, 1'b0, 1'b1, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL bp_first got=%b exp=1", rdy); end
        step(1'b1, 32'hB0000001, 1'b0, 1'b1, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL bp_second got=%b exp=1", rdy); end
        step(1'b1, 32'hB0000002, 1'b0, 1'b0, rdy);
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL bp_third_block got=%b exp=0", rdy); end
        step(1'b1, 32'hC0000000, 1'b1, 1'b1, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL bp_ch1_indep got=%b exp=1", rdy); end
        // Consumer ready does not reach in_ready in the popping cycle itself.
        out0_ready = 1'b1;
        step(1'b1, 32'hB0000002, 1'b0, 1'b0, rdy);
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL bp_pop_cycle got=%b exp=0", rdy); end
        out0_ready = 1'b0;
        step(1'b1, 32'hB0000002, 1'b0, 1'b1, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL bp_after_pop got=%b exp=1", rdy); end
        out0_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        checks++;
        if (out0_valid !== 1'b0 || q0.size() != 0) begin
            failures++;
            $display("FAIL bp_drain got v0=%b left=%0d exp 0 0", out0_valid, q0.size());
        end
    endtask

    task automatic test_simultaneous();
        logic rdy;
        out1_ready = 1'b0;
        step(1'b1, 32'hD0000000, 1'b1, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1 || out1_valid !== 1'b1 || out1_data !== 32'hD0000000) begin
            failures++;
            $display("FAIL sim_setup got rdy=%b v1=%b d1=%h exp 1 1 d0000000", rdy, out1_valid, out1_data);
        end
        out1_ready = 1'b1;
        step(1'b1, 32'hD0000001, 1'b1, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1 || out1_valid !== 1'b1 || out1_data !== 32'hD0000001) begin
            failures++;
            $display("FAIL sim_pushpop got rdy=%b v1=%b d1=%h exp 1 1 d0000001", rdy, out1_valid, out1_data);
        end
        // Occupancy must still be 1: exactly one more word fits.
        out1_ready = 1'b0;
        step(1'b1, 32'hD0000002, 1'b1, 1'b1, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL sim_occ_room got=%b exp=1", rdy); end
        step(1'b1, 32'hD0000003, 1'b1, 1'b0, rdy);
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL sim_occ_full got=%b exp=0", rdy); end
        out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, rdy);
    endtask

    task automatic test_counter_wrap();
        logic rdy;
        logic [7:0] start0, start1, prev;
        out0_ready = 1'b1; out1_ready = 1'b1;
        start0 = exp_cnt0; start1 = exp_cnt1;
        for (int i = 0; i < 256; i++) begin
            prev = exp_cnt0;
            step(1'b1, 32'hE0000000 + 32'(i), 1'b0, 1'b1, rdy);
            checks++;
            if (rdy !== 1'b1 || cnt0 !== exp_cnt0) begin
                failures++;
                $display("FAIL wrap_cnt i=%0d got rdy=%b cnt0=%0d exp 1 %0d", i, rdy, cnt0, exp_cnt0);
            end
            if (prev == 8'd255) begin
                checks++;
                if (cnt0 !== 8'd0) begin
                    failures++;
                    $display("FAIL wrap_255_to_0 got=%0d exp=0", cnt0);
                end
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        checks++;
        if (cnt0 !== start0 || cnt1 !== start1) begin
            failures++;
            $display("FAIL wrap_final got cnt0=%0d cnt1=%0d exp %0d %0d", cnt0, cnt1, start0, start1);
        end
    endtask

    task automatic test_mid_reset();
        logic rdy;
        out0_ready = 1'b0; out1_ready = 1'b0;
        step(1'b1, 32'hF0000000, 1'b0, 1'b1, rdy);
        step(1'b1, 32'hF0000001, 1'b0, 1'b1, rdy);
        step(1'b1, 32'hF0000002, 1'b1, 1'b1, rdy);
        step(1'b1, 32'hF0000003, 1'b1, 1'b1, rdy);
        in_valid = 1'b0; in_sel = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL mr_full0 got=%b exp=0", in_ready); end
        in_sel = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL mr_full1 got=%b exp=0", in_ready); end
        // Reset with live handshakes on every port; all of them must be discarded.
        mon_en = 1'b0;
        reset_n = 1'b0; in_valid = 1'b1; in_data = 32'h12345678; in_sel = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        @(posedge clk); #1;
        q0.delete(); q1.delete(); exp_cnt0 = 8'd0; exp_cnt1 = 8'd0;
        reset_n = 1'b1; in_valid = 1'b0;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0 ||
            out0_data !== 32'h0 || out1_data !== 32'h0) begin
            failures++;
            $display("FAIL mr_cleared got v0=%b v1=%b cnt0=%0d cnt1=%0d d0=%h d1=%h exp all 0",
                     out0_valid, out1_valid, cnt0, cnt1, out0_data, out1_data);
        end
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mr_after got v0=%b v1=%b rdy=%b exp 0 0 1", out0_valid, out1_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_counter_wrap();
        test_mid_reset();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL undelivered got q0=%0d q1=%0d exp 0 0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
